demux_vc: RTL

DEMUX_VC -- requirements
Module: demux_vc

---
 rtl/demux_vc.sv | 134 +++++++++++++
 1 files changed

// File: rtl/demux_vc.sv
// Two-entry in-order holding buffer that routes {selector,data} words to one of
// two virtual-channel FIFOs, with registered push strobes and per-VC push counters.
module demux_vc #(
  parameter int DATA_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 valid_in,
  input  logic                 selector,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 full_VC0,
  input  logic                 full_VC1,
  output logic                 ready_out,
  output logic                 push_VC0,
  output logic                 push_VC1,
  output logic [DATA_SIZE-1:0] data_VC0,
  output logic [DATA_SIZE-1:0] data_VC1,
  output logic [7:0]           pkt_cnt_VC0,
  output logic [7:0]           pkt_cnt_VC1,
  output logic                 idle_out,
  output logic [1:0]           state_dbg
);

  // Handshake: a word transfers at a rising edge iff valid_in && ready_out;
  // ready_out depends on the registered buffer count only.
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, STALL = 2'd2} state_t;

  localparam int EW = DATA_SIZE + 1;

  state_t                 state_q, state_d;
  logic [EW-1:0]          buf_q [2];
  logic [EW-1:0]          buf_d [2];
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   push0_q, push0_d;
  logic                   push1_q, push1_d;
  logic [DATA_SIZE-1:0]   data0_q, data0_d;
  logic [DATA_SIZE-1:0]   data1_q, data1_d;
  logic [7:0]             cnt0_q, cnt0_d;
  logic [7:0]             cnt1_q, cnt1_d;
  logic [EW-1:0]          head;
  logic                   accept;
  logic                   dispatch;

  always_comb begin
    head     = buf_q[rd_ptr_q];
    accept   = valid_in && (count_q < 2'd2);
    // The head blocks everything behind it, whichever VC that entry targets.
    dispatch = (count_q != 2'd0) && !(head[DATA_SIZE] ? full_VC1 : full_VC0);

    buf_d    = buf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    push0_d  = 1'b0;
    push1_d  = 1'b0;
    data0_d  = data0_q;
    data1_d  = data1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    state_d  = state_q;

    if (accept) begin
      buf_d[wr_ptr_q] = {selector, data_in};
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (dispatch) begin
      rd_ptr_d = ~rd_ptr_q;
      if (head[DATA_SIZE]) begin
        push1_d = 1'b1;
        data1_d = head[DATA_SIZE-1:0];
        cnt1_d  = cnt1_q + 8'd1;
      end else begin
        push0_d = 1'b1;
        data0_d = head[DATA_SIZE-1:0];
        cnt0_d  = cnt0_q + 8'd1;
      end
    end

    count_d = count_q + {1'b0, accept} - {1'b0, dispatch};

    case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE,
      STALL: begin
        if (count_d == 2'd0)  state_d = IDLE;
        else if (!dispatch)   state_d = STALL;
        else                  state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      push0_q  <= 1'b0;
      push1_q  <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt0_q   <= 8'd0;
      cnt1_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      push0_q  <= push0_d;
      push1_q  <= push1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign ready_out   = (count_q < 2'd2);
  assign push_VC0    = push0_q;
  assign push_VC1    = push1_q;
  assign data_VC0    = data0_q;
  assign data_VC1    = data1_q;
  assign pkt_cnt_VC0 = cnt0_q;
  assign pkt_cnt_VC1 = cnt1_q;
  assign idle_out    = (state_q == IDLE) && !push0_q && !push1_q;
  assign state_dbg   = state_q;

endmodule
